// File: rtl/fadd_norm_round.sv
// Normalise-and-round back end of the binary32 adder: two-stage valid/ready pipeline producing packed IEEE-754.
// Define FADD_NR_RNE_EN for round-to-nearest-even; otherwise rounds toward zero and saturates on overflow.
module fadd_norm_round #(
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned FRAC_W = 23
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sign,
    input  logic [EXP_W-1:0]        in_exp,
    input  logic [FRAC_W+3:0]       in_mant,
    input  logic                    in_sticky,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+FRAC_W:0]   out_d,
    output logic                    out_overflow,
    output logic                    out_underflow
);

    localparam int unsigned MANT_W = FRAC_W + 4;
    localparam int unsigned NORM_W = MANT_W - 1;
    localparam int unsigned RND_W  = FRAC_W + 2;
    localparam int unsigned LZ_W   = $clog2(NORM_W + 1);
    localparam int unsigned XE_W   = EXP_W + 2;
    localparam int unsigned E1_W   = EXP_W + 1;
    localparam int unsigned F1_W   = FRAC_W + 1;
    localparam int unsigned DATA_W = EXP_W + FRAC_W + 1;
    localparam logic [EXP_W-1:0] EXP_MAX = '1;

`ifdef FADD_NR_RNE_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    // Leading zeros counted from the hidden-bit position downward.
    function automatic logic [LZ_W-1:0] lead_zeros(input logic [NORM_W-1:0] m);
        logic [LZ_W-1:0] n;
        logic            found;
        n     = '0;
        found = 1'b0;
        for (int i = NORM_W - 1; i >= 0; i--) begin
            if (!found) begin
                if (m[i]) found = 1'b1;
                else      n = n + LZ_W'(1);
            end
        end
        return n;
    endfunction

    // Infinity under RNE; largest finite magnitude when truncating.
    function automatic logic [DATA_W-1:0] ovf_value(input logic sign);
        if (RNE) return {sign, EXP_MAX, {FRAC_W{1'b0}}};
        return {sign, EXP_MAX - EXP_W'(1), {FRAC_W{1'b1}}};
    endfunction

    logic                adv;
    logic                load1;

    logic                s1_valid_q,  s1_valid_d;
    logic                s1_sign_q,   s1_sign_d;
    logic [EXP_W-1:0]    s1_exp_q,    s1_exp_d;
    logic [RND_W-1:0]    s1_mant_q,   s1_mant_d;
    logic                s1_sticky_q, s1_sticky_d;
    logic                s1_zero_q,   s1_zero_d;
    logic                s1_uf_q,     s1_uf_d;
    logic                s1_of_q,     s1_of_d;

    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_d_q,     out_d_d;
    logic                out_of_q,    out_of_d;
    logic                out_uf_q,    out_uf_d;

    logic [LZ_W-1:0]     lz;
    logic [XE_W-1:0]     xexp;
    logic [FRAC_W-1:0]   frac;
    logic                rnd_g;
    logic                rnd_s;
    logic                rnd_inc;
    logic [F1_W-1:0]     frac_sum;
    logic [E1_W-1:0]     exp_rnd;

    assign adv      = !out_valid_q || out_ready;
    assign load1    = adv && in_valid;
    assign in_ready = adv;

    // Stage 1: classify and normalise the raw sum.
    always_comb begin
        s1_valid_d  = adv ? in_valid : s1_valid_q;
        s1_sign_d   = s1_sign_q;
        s1_exp_d    = s1_exp_q;
        s1_mant_d   = s1_mant_q;
        s1_sticky_d = s1_sticky_q;
        s1_zero_d   = s1_zero_q;
        s1_uf_d     = s1_uf_q;
        s1_of_d     = s1_of_q;
        lz          = lead_zeros(in_mant[NORM_W-1:0]);
        xexp        = '0;
        if (load1) begin
            s1_sign_d   = in_sign;
            s1_exp_d    = '0;
            s1_mant_d   = '0;
            s1_sticky_d = in_sticky;
            s1_zero_d   = 1'b0;
            s1_uf_d     = 1'b0;
            s1_of_d     = 1'b0;
            if (in_exp == EXP_MAX) begin
                s1_of_d = 1'b1;
            end else if (in_mant == '0) begin
                // Only sticky left means a nonzero magnitude too small to represent.
                s1_zero_d = !in_sticky;
                s1_uf_d   = in_sticky;
                s1_sign_d = in_sign && in_sticky;
            end else begin
                if (in_mant[MANT_W-1]) begin
                    s1_mant_d   = in_mant[MANT_W-2:1];
                    s1_sticky_d = in_sticky || in_mant[0];
                    xexp        = XE_W'(in_exp) + XE_W'(1);
                end else begin
                    s1_mant_d = in_mant[NORM_W-2:0] << lz;
                    xexp      = XE_W'(in_exp) - XE_W'(lz);
                end
                if (xexp[XE_W-1] || xexp == '0) s1_uf_d = 1'b1;
                else if (xexp >= XE_W'(EXP_MAX)) s1_of_d = 1'b1;
                else s1_exp_d = xexp[EXP_W-1:0];
            end
        end
    end

    // Stage 2: round, handle fraction carry-out and pack the result.
    always_comb begin
        frac        = s1_mant_q[RND_W-1:2];
        rnd_g       = s1_mant_q[1];
        rnd_s       = s1_mant_q[0] || s1_sticky_q;
        rnd_inc     = RNE && rnd_g && (rnd_s || frac[0]);
        frac_sum    = {1'b0, frac} + F1_W'(rnd_inc);
        exp_rnd     = {1'b0, s1_exp_q} + E1_W'(frac_sum[FRAC_W]);
        out_valid_d = adv ? s1_valid_q : out_valid_q;
        out_d_d     = out_d_q;
        out_of_d    = out_of_q;
        out_uf_d    = out_uf_q;
        if (adv && s1_valid_q) begin
            out_of_d = 1'b0;
            out_uf_d = 1'b0;
            if (s1_zero_q) begin
                out_d_d = '0;
            end else if (s1_uf_q) begin
                out_d_d  = {s1_sign_q, {(DATA_W-1){1'b0}}};
                out_uf_d = 1'b1;
            end else if (s1_of_q || exp_rnd >= E1_W'(EXP_MAX)) begin
                out_d_d  = ovf_value(s1_sign_q);
                out_of_d = 1'b1;
            end else begin
                out_d_d = {s1_sign_q, exp_rnd[EXP_W-1:0], frac_sum[FRAC_W-1:0]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_exp_q    <= '0;
            s1_mant_q   <= '0;
            s1_sticky_q <= 1'b0;
            s1_zero_q   <= 1'b0;
            s1_uf_q     <= 1'b0;
            s1_of_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_d_q     <= '0;
            out_of_q    <= 1'b0;
            out_uf_q    <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sign_q   <= s1_sign_d;
            s1_exp_q    <= s1_exp_d;
            s1_mant_q   <= s1_mant_d;
            s1_sticky_q <= s1_sticky_d;
            s1_zero_q   <= s1_zero_d;
            s1_uf_q     <= s1_uf_d;
            s1_of_q     <= s1_of_d;
            out_valid_q <= out_valid_d;
            out_d_q     <= out_d_d;
            out_of_q    <= out_of_d;
            out_uf_q    <= out_uf_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_d         = out_d_q;
    assign out_overflow  = out_of_q;
    assign out_underflow = out_uf_q;

endmodule

// File: tb/tb_fadd_norm_round.sv
// Self-checking bench for fadd_norm_round: directed corner vectors plus randomized handshake traffic
// checked against a bit-position reference model. Honours FADD_NR_RNE_EN like the design.
module tb_fadd_norm_round;

`ifdef FADD_NR_RNE_EN
    localparam bit RNE_TB = 1'b1;
`else
    localparam bit RNE_TB = 1'b0;
`endif

    typedef struct packed {logic [31:0] d; logic of; logic uf;} res_t;
    typedef struct packed {logic s; logic [7:0] e; logic [26:0] m; logic st;} beat_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [26:0] in_mant;
    logic        in_sticky;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_d;
    logic        out_overflow;
    logic        out_underflow;

    int   total = 0;
    int   bad   = 0;
    res_t expq[$];

    fadd_norm_round dut (
        .clk           (clk),
        .rstn          (rstn),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_sign       (in_sign),
        .in_exp        (in_exp),
        .in_mant       (in_mant),
        .in_sticky     (in_sticky),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_d         (out_d),
        .out_overflow  (out_overflow),
        .out_underflow (out_underflow)
    );

    always #5 clk = ~clk;

    function automatic res_t sat_res(input logic s);
        res_t r;
        r.d  = RNE_TB ? {s, 8'hFF, 23'h000000} : {s, 8'hFE, 23'h7FFFFF};
        r.of = 1'b1;
        r.uf = 1'b0;
        return r;
    endfunction

    // Locate the leading one, take the top 24 bits as significand, round from the bits below.
    function automatic res_t ref_model(input beat_t b);
        res_t        r;
        int          p;
        int          ee;
        logic [24:0] kept;
        logic        g;
        logic        rest;
        r = '0;
        if (b.e == 8'hFF) return sat_res(b.s);
        if (b.m == 27'd0) begin
            if (b.st) begin
                r.d  = {b.s, 31'd0};
                r.uf = 1'b1;
            end
            return r;
        end
        p = 26;
        while (!b.m[p]) p--;
        ee = int'(b.e) + p - 25;
        if (ee <= 0) begin
            r.d  = {b.s, 31'd0};
            r.uf = 1'b1;
            return r;
        end
        if (ee >= 255) return sat_res(b.s);
        if (p >= 24) begin
            kept = 25'(b.m >> (p - 23));
            g    = b.m[p-24];
            rest = (p >= 25) && ((b.m & ((27'd1 << (p - 24)) - 27'd1)) != 27'd0);
        end else begin
            kept = 25'(b.m << (23 - p));
            g    = 1'b0;
            rest = 1'b0;
        end
        rest = rest || b.st;
        if (RNE_TB && g && (rest || kept[0])) kept = kept + 25'd1;
        if (kept[24]) begin
            kept = 25'h0800000;
            ee++;
        end
        if (ee >= 255) return sat_res(b.s);
        r.d = {b.s, 8'(ee), 23'(kept)};
        return r;
    endfunction

    function automatic beat_t rand_beat();
        beat_t b;
        int    k;
        b.s = 1'($urandom);
        k   = $urandom_range(0, 11);
        case (k)
            0:       b.e = 8'd0;
            1:       b.e = 8'd1;
            2:       b.e = 8'd2;
            3:       b.e = 8'd253;
            4:       b.e = 8'd254;
            5:       b.e = 8'd255;
            default: b.e = 8'($urandom_range(1, 254));
        endcase
        b.m  = 27'($urandom) >> $urandom_range(0, 26);
        b.st = 1'($urandom);
        if ($urandom_range(0, 5) == 0) begin
            b.m[1:0] = 2'b10;
            b.st     = 1'b0;
        end
        if (b.m == 27'd0) b.st = 1'b0;
        return b;
    endfunction

    task automatic put_beat(input beat_t b, input logic v);
        in_valid  = v;
        in_sign   = b.s;
        in_exp    = b.e;
        in_mant   = b.m;
        in_sticky = b.st;
    endtask

    task automatic test_reset();
        rstn      = 1'b0;
        out_ready = 1'b0;
        put_beat('0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
        total++;
        if (out_d !== 32'd0) begin bad++; $display("FAIL reset_out_d got=%h want=00000000", out_d); end
        total++;
        if ({out_overflow, out_underflow} !== 2'b00) begin
            bad++; $display("FAIL reset_flags got=%b want=00", {out_overflow, out_underflow});
        end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
        rstn = 1'b1;
    endtask

    task automatic test_directed();
        beat_t b[10];
        res_t  w[10];
        b[0] = '{1'b0, 8'd127, 27'h4000000, 1'b0}; w[0] = '{32'h40000000, 1'b0, 1'b0};
        b[1] = '{1'b1, 8'd127, 27'h0000000, 1'b0}; w[1] = '{32'h00000000, 1'b0, 1'b0};
        b[2] = '{1'b0, 8'd1,   27'h0800000, 1'b0}; w[2] = '{32'h00000000, 1'b0, 1'b1};
        b[3] = '{1'b1, 8'd1,   27'h0800000, 1'b0}; w[3] = '{32'h80000000, 1'b0, 1'b1};
        b[4] = '{1'b0, 8'd127, 27'h2000006, 1'b0};
        w[4] = '{RNE_TB ? 32'h3F800002 : 32'h3F800001, 1'b0, 1'b0};
        b[5] = '{1'b0, 8'd127, 27'h3FFFFFF, 1'b0};
        w[5] = '{RNE_TB ? 32'h40000000 : 32'h3FFFFFFF, 1'b0, 1'b0};
        b[6] = '{1'b0, 8'd254, 27'h4000000, 1'b0};
        w[6] = '{RNE_TB ? 32'h7F800000 : 32'h7F7FFFFF, 1'b1, 1'b0};
        b[7] = '{1'b1, 8'd255, 27'h2000000, 1'b0};
        w[7] = '{RNE_TB ? 32'hFF800000 : 32'hFF7FFFFF, 1'b1, 1'b0};
        b[8] = '{1'b0, 8'd127, 27'h200000A, 1'b0}; w[8] = '{32'h3F800002, 1'b0, 1'b0};
        b[9] = '{1'b0, 8'd1,   27'h2000000, 1'b0}; w[9] = '{32'h00800000, 1'b0, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            out_ready = 1'b1;
            put_beat(b[i], 1'b1);
            @(negedge clk);
            in_valid = 1'b0;
            total++;
            if (out_valid !== 1'b0) begin bad++; $display("FAIL dir%0d_early got=%0b want=0", i, out_valid); end
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || out_d !== w[i].d || out_overflow !== w[i].of || out_underflow !== w[i].uf) begin
                bad++;
                $display("FAIL dir%0d got v=%0b d=%h of=%0b uf=%0b want v=1 d=%h of=%0b uf=%0b",
                         i, out_valid, out_d, out_overflow, out_underflow, w[i].d, w[i].of, w[i].uf);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        beat_t b[4];
        res_t  e;
        int    sent = 0;
        int    got  = 0;
        int    cyc  = 0;
        logic  held = 1'b0;
        logic [31:0] held_d = '0;
        for (int i = 0; i < 4; i++) b[i] = rand_beat();
        expq.delete();
        while ((sent < 4 || got < 4) && cyc < 40) begin
            @(negedge clk);
            out_ready = !(cyc >= 2 && cyc < 5);
            if (sent < 4) put_beat(b[sent], 1'b1);
            else          in_valid = 1'b0;
            #1;
            if (held) begin
                total++;
                if (out_valid !== 1'b1 || out_d !== held_d) begin
                    bad++; $display("FAIL bp_stable got v=%0b d=%h want v=1 d=%h", out_valid, out_d, held_d);
                end
            end
            held = 1'b0;
            if (out_valid && !out_ready) begin
                total++;
                if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%0b want=0", in_ready); end
                held   = 1'b1;
                held_d = out_d;
            end
            if (in_valid && in_ready) begin
                expq.push_back(ref_model(b[sent]));
                sent++;
            end
            if (out_valid && out_ready) begin
                total++;
                if (expq.size() == 0) begin
                    bad++; $display("FAIL bp_extra got d=%h want none", out_d);
                end else begin
                    e = expq.pop_front();
                    if (out_d !== e.d || out_overflow !== e.of || out_underflow !== e.uf) begin
                        bad++;
                        $display("FAIL bp_res%0d got d=%h of=%0b uf=%0b want d=%h of=%0b uf=%0b",
                                 got, out_d, out_overflow, out_underflow, e.d, e.of, e.uf);
                    end
                end
                got++;
            end
            cyc++;
        end
        in_valid = 1'b0;
        total++;
        if (sent != 4 || got != 4 || expq.size() != 0) begin
            bad++; $display("FAIL bp_count got sent=%0d recv=%0d want 4/4", sent, got);
        end
    endtask

    task automatic test_random();
        beat_t cur;
        res_t  e;
        int    sent = 0;
        int    got  = 0;
        int    cyc  = 0;
        logic  pres = 1'b0;
        expq.delete();
        cur = rand_beat();
        while ((sent < 300 || expq.size() != 0) && cyc < 4000) begin
            @(negedge clk);
            out_ready = (sent < 300) ? ($urandom_range(0, 9) < 7) : 1'b1;
            if (!pres && sent < 300) pres = ($urandom_range(0, 9) < 7);
            put_beat(cur, pres);
            #1;
            if (in_valid && in_ready) begin
                expq.push_back(ref_model(cur));
                sent++;
                cur  = rand_beat();
                pres = 1'b0;
            end
            if (out_valid && out_ready) begin
                total++;
                if (expq.size() == 0) begin
                    bad++; $display("FAIL rnd_extra got d=%h want none", out_d);
                end else begin
                    e = expq.pop_front();
                    if (out_d !== e.d || out_overflow !== e.of || out_underflow !== e.uf) begin
                        bad++;
                        $display("FAIL rnd_res%0d got d=%h of=%0b uf=%0b want d=%h of=%0b uf=%0b",
                                 got, out_d, out_overflow, out_underflow, e.d, e.of, e.uf);
                    end
                end
                got++;
            end
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        total++;
        if (sent != 300 || got != 300 || expq.size() != 0) begin
            bad++; $display("FAIL rnd_count got sent=%0d recv=%0d want 300/300", sent, got);
        end
    endtask

    task automatic test_reset_in_flight();
        beat_t b0;
        beat_t b2;
        res_t  e;
        b0 = '{1'b0, 8'd127, 27'h4000000, 1'b0};
        b2 = rand_beat();
        e  = ref_model(b2);
        @(negedge clk);
        out_ready = 1'b1;
        put_beat(b0, 1'b1);
        @(negedge clk);
        put_beat(b0, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        rstn     = 1'b0;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || out_d !== 32'd0) begin
            bad++; $display("FAIL rst_flight got v=%0b d=%h want v=0 d=00000000", out_valid, out_d);
        end
        total++;
        if ({out_overflow, out_underflow} !== 2'b00) begin
            bad++; $display("FAIL rst_flight_flags got=%b want=00", {out_overflow, out_underflow});
        end
        rstn = 1'b1;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_discard got=%0b want=0", out_valid); end
        put_beat(b2, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_lat_early got=%0b want=0", out_valid); end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || out_d !== e.d || out_overflow !== e.of || out_underflow !== e.uf) begin
            bad++;
            $display("FAIL rst_next got v=%0b d=%h of=%0b uf=%0b want v=1 d=%h of=%0b uf=%0b",
                     out_valid, out_d, out_overflow, out_underflow, e.d, e.of, e.uf);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_in_flight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
